register_8bit: RTL and testbench

//   General-purpose 8-bit storage register with synchronous parallel load and

---
 rtl/datapath_pkg.sv | 7 +
 rtl/dff_bit_en.sv | 25 ++
 rtl/register_8bit.sv | 57 +++++
 tb/tb_register_8bit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types and constants.
// Used by register_8bit and its bit cell.
package datapath_pkg;
  localparam int DATA_WIDTH = 8;
  typedef logic [DATA_WIDTH-1:0] data_t;
  localparam data_t CLEAR_DEFAULT = '0;
endpackage

// File: rtl/dff_bit_en.sv
// Single-bit flop with load enable and
// asynchronous active-high clear.
module dff_bit_en #(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // Clear wins at once; otherwise capture on enable.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr)
      r_q <= CLR_VAL;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_8bit.sv
// Holding register with load enable and async clear.
// REGISTER_8BIT_PARITY_EN adds a registered parity output.
module register_8bit
  import datapath_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = CLEAR_DEFAULT
) (
  input  logic             Load,
  input  logic             Clear,
  input  logic             Clock,
  input  logic [WIDTH-1:0] inData,
`ifdef REGISTER_8BIT_PARITY_EN
  output logic [WIDTH-1:0] outData,
  output logic             outParity
`else
  output logic [WIDTH-1:0] outData
`endif
);

  logic [WIDTH-1:0] w_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dff_bit_en #(
      .CLR_VAL (CLEAR_VALUE[g])
    ) u_bit (
      .i_clk (Clock),
      .i_clr (Clear),
      .i_en  (Load),
      .i_d   (inData[g]),
      .o_q   (w_q[g])
    );
  end

  assign outData = w_q;

`ifdef REGISTER_8BIT_PARITY_EN
  logic w_par_d;
  logic w_par_q;

  // Parity of the incoming word is latched with it.
  assign w_par_d = ^inData;

  dff_bit_en #(
    .CLR_VAL (^CLEAR_VALUE)
  ) u_par (
    .i_clk (Clock),
    .i_clr (Clear),
    .i_en  (Load),
    .i_d   (w_par_d),
    .o_q   (w_par_q)
  );

  assign outParity = w_par_q;
`endif

endmodule

// File: tb/tb_register_8bit.sv
// Directed + random checks of register_8bit
// against a value-level reference model.
module tb_register_8bit;

  logic       Clock;
  logic       Clear;
  logic       Load;
  logic [7:0] inData;
  logic [7:0] outData;
`ifdef REGISTER_8BIT_PARITY_EN
  logic       outParity;
`endif

  int n_vec;
  int n_err;
  logic [7:0] exp_q;

  register_8bit dut (
    .Load    (Load),
    .Clear   (Clear),
    .Clock   (Clock),
    .inData  (inData),
`ifdef REGISTER_8BIT_PARITY_EN
    .outData (outData),
    .outParity (outParity)
`else
    .outData (outData)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [7:0] exp);
    n_vec++;
    assert (outData === exp)
    else begin
      n_err++;
      $error("FAIL %s: outData=%h expected=%h", tag, outData, exp);
    end
`ifdef REGISTER_8BIT_PARITY_EN
    n_vec++;
    assert (outParity === ($countones(exp) % 2 == 1))
    else begin
      n_err++;
      $error("FAIL %s_par: outParity=%b expected=%b",
             tag, outParity, ($countones(exp) % 2 == 1));
    end
`endif
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    Clear  = 1'b0;
    Load   = 1'b0;
    inData = 8'd0;

    // 1: async clear before any edge
    #10;
    Clear  = 1'b1;
    inData = 8'd5;
    #1 check("clr_async", 8'd0);

    // 2: load 10 after release
    #9;
    Clear  = 1'b0;
    Load   = 1'b1;
    inData = 8'd10;
    #1 check("clr_release", 8'd0);
    #5 check("load10", 8'd10);

    // 3: hold with Load=0
    #4;
    Load   = 1'b0;
    inData = 8'd5;
    #6 check("hold35", 8'd10);

    // 4: clear priority over load
    #4;
    Load  = 1'b1;
    Clear = 1'b1;
    #1 check("clr_prio", 8'd0);
    #5 check("clr_prio_edge", 8'd0);
    #4;
    Clear = 1'b0;
    Load  = 1'b0;
    #6 check("post_clr_hold", 8'd0);

    // 5: clear pulse between edges
    #4;
    Load   = 1'b1;
    inData = 8'hA5;
    #6 check("loadA5", 8'hA5);
    #2 Load = 1'b0;
    #2 Clear = 1'b1;
    #1 check("pulse_clr", 8'd0);
    #1 Clear = 1'b0;
    #1 check("pulse_rel", 8'd0);
    #3 check("pulse_edge", 8'd0);

    // 6: parity patterns
    #4;
    Load   = 1'b1;
    inData = 8'h07;
    #6 check("load07", 8'h07);
    #4 inData = 8'h03;
    #6 check("load03", 8'h03);
    #4 Load = 1'b0;
    Clear = 1'b1;
    #1 check("par_clr", 8'd0);
    #1 Clear = 1'b0;
    exp_q = 8'd0;

    // random: model stores value seen at each edge
    for (int i = 0; i < 300; i++) begin
      @(posedge Clock);
      if (Clear)
        exp_q = 8'd0;
      else if (Load)
        exp_q = inData;
      #1 check("rnd_edge", exp_q);
      #1;
      Clear  = ($urandom_range(0, 7) == 0);
      Load   = ($urandom_range(0, 1) == 1);
      inData = 8'($urandom);
      if (Clear)
        exp_q = 8'd0;
      #1 check("rnd_async", exp_q);
      #1 inData = 8'($urandom);
      if (Clear && ($urandom_range(0, 1) == 1))
        #1 Clear = 1'b0;
      #1 check("rnd_glitch", exp_q);
      #1 inData = 8'($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
